// File: rtl/game_pkg.sv
// Shared constants, player mode type and seven-segment glyph decode
// for the jump game debug build.
package game_pkg;

   localparam int VGA_H_VIS  = 640;
   localparam int VGA_H_FP   = 16;
   localparam int VGA_H_SYNC = 96;
   localparam int VGA_H_BP   = 48;
   localparam int VGA_V_VIS  = 480;
   localparam int VGA_V_FP   = 10;
   localparam int VGA_V_SYNC = 2;
   localparam int VGA_V_BP   = 33;

   localparam logic [9:0] FLOOR_TOP   = 10'd464;
   localparam logic [9:0] FLOOR_BOT   = 10'd479;
   localparam logic [9:0] PLAYER_SIZE = 10'd16;

   localparam logic [11:0] COL_PLAYER = 12'hF00;
   localparam logic [11:0] COL_FLOOR  = 12'h840;
   localparam logic [11:0] COL_SKY    = 12'h0AF;

   localparam logic [9:0]        Y_GROUND   = 10'd448;
   localparam logic [9:0]        X_MAX      = 10'd624;
   localparam logic [9:0]        X_RESET    = 10'd312;
   localparam logic signed [5:0] VY_MAX     = 6'sd8;
   localparam logic [4:0]        CHARGE_MAX = 5'd31;

   typedef enum logic {
      PM_GROUND = 1'b0,
      PM_AIR    = 1'b1
   } phys_mode_t;

   // Active-low segments, packed {a,b,c,d,e,f,g}.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'b0000001;
         4'h1: seg = 7'b1001111;
         4'h2: seg = 7'b0010010;
         4'h3: seg = 7'b0000110;
         4'h4: seg = 7'b1001100;
         4'h5: seg = 7'b0100100;
         4'h6: seg = 7'b0100000;
         4'h7: seg = 7'b0001111;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0000100;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b1100000;
         4'hC: seg = 7'b0110001;
         4'hD: seg = 7'b1000010;
         4'hE: seg = 7'b0110000;
         default: seg = 7'b0111000;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// Pixel-rate divider and raster counters; raw (unregistered) syncs,
// visible flag, and a one-cycle frame tick at the start of vertical blank.
module vga_sync_gen
   import game_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int H_VIS   = VGA_H_VIS,
   parameter int H_FP    = VGA_H_FP,
   parameter int H_SYNC  = VGA_H_SYNC,
   parameter int H_BP    = VGA_H_BP,
   parameter int V_VIS   = VGA_V_VIS,
   parameter int V_FP    = VGA_V_FP,
   parameter int V_SYNC  = VGA_V_SYNC,
   parameter int V_BP    = VGA_V_BP
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pix_tick,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic       hsync_raw,
   output logic       vsync_raw,
   output logic       visible,
   output logic       frame_tick
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [9:0]       h_next;
   logic [9:0]       v_next;

   assign pix_tick = (div_cnt == '0);

   always_comb begin
      h_next = h_cnt + 10'd1;
      v_next = v_cnt;
      if (h_cnt == 10'(H_TOT - 1)) begin
         h_next = '0;
         if (v_cnt == 10'(V_TOT - 1)) v_next = '0;
         else                          v_next = v_cnt + 10'd1;
      end
   end

   // Divider is a reload down-counter; the tick is its terminal count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt    <= DIV_LOAD;
         h_cnt      <= '0;
         v_cnt      <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= 1'b0;
         if (pix_tick) begin
            div_cnt    <= DIV_LOAD;
            h_cnt      <= h_next;
            v_cnt      <= v_next;
            frame_tick <= (h_next == '0) && (v_next == 10'(V_VIS));
         end else begin
            div_cnt <= div_cnt - DIV_W'(1);
         end
      end
   end

   assign hsync_raw = !((h_cnt >= 10'(H_VIS + H_FP)) &&
                        (h_cnt <  10'(H_VIS + H_FP + H_SYNC)));
   assign vsync_raw = !((v_cnt >= 10'(V_VIS + V_FP)) &&
                        (v_cnt <  10'(V_VIS + V_FP + V_SYNC)));
   assign visible   = (h_cnt < 10'(H_VIS)) && (v_cnt < 10'(V_VIS));

endmodule

// File: rtl/top_debug_game.sv
// Jump game debug top: synchronised buttons, per-frame player physics,
// VGA scene rendering and a scanned seven-segment readout of player state.
//
//   mode      | meaning
//   ----------+-------------------------------------------------------------
//   PM_GROUND | on the floor: walk, or charge while jump held; launch on release
//   PM_AIR    | ballistic flight, buttons ignored, wall bounce, land at y=448
module top_debug_game
   import game_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int WALK_SPD = 2,
   parameter int SCAN_BIT = 17,
   parameter int H_VIS    = VGA_H_VIS,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_VIS    = VGA_V_VIS,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        left,
   input  logic        right,
   input  logic        jump,
   output logic        hsync,
   output logic        vsync,
   output logic [11:0] rgb,
   output logic        CA,
   output logic        CB,
   output logic        CC,
   output logic        CD,
   output logic        CE,
   output logic        CF,
   output logic        CG,
   output logic        DP,
   output logic [7:0]  AN
);

   // Historical name: this reset is active high.
   logic rst;
   assign rst = sys_rst_n;

   logic [1:0] left_sync, right_sync, jump_sync;
   logic       left_s, right_s, jump_s;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         left_sync  <= '0;
         right_sync <= '0;
         jump_sync  <= '0;
      end else begin
         left_sync  <= {left_sync[0],  left};
         right_sync <= {right_sync[0], right};
         jump_sync  <= {jump_sync[0],  jump};
      end
   end

   assign left_s  = left_sync[1];
   assign right_s = right_sync[1];
   assign jump_s  = jump_sync[1];

   logic       pix_tick, hs_raw, vs_raw, visible, frame_tick;
   logic [9:0] h_cnt, v_cnt;

   vga_sync_gen #(
      .CLK_DIV (CLK_DIV),
      .H_VIS   (H_VIS),
      .H_FP    (H_FP),
      .H_SYNC  (H_SYNC),
      .H_BP    (H_BP),
      .V_VIS   (V_VIS),
      .V_FP    (V_FP),
      .V_SYNC  (V_SYNC),
      .V_BP    (V_BP)
   ) u_vga_sync_gen (
      .clk        (sys_clk),
      .rst        (rst),
      .pix_tick   (pix_tick),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .hsync_raw  (hs_raw),
      .vsync_raw  (vs_raw),
      .visible    (visible),
      .frame_tick (frame_tick)
   );

   phys_mode_t        mode;
   logic [9:0]        pos_x, pos_y;
   logic signed [5:0] vel_y;
   logic signed [2:0] vel_x;
   logic [4:0]        charge;
   logic              armed;

   logic signed [11:0] x_air, y_air;
   logic signed [5:0]  vy_inc, vy_launch;
   logic signed [2:0]  vx_launch;
   logic [9:0]         x_right, x_left;

   always_comb begin
      x_air     = $signed({2'b00, pos_x}) + $signed({{9{vel_x[2]}}, vel_x});
      y_air     = $signed({2'b00, pos_y}) + $signed({{6{vel_y[5]}}, vel_y});
      vy_inc    = (vel_y >= VY_MAX) ? VY_MAX : vel_y + 6'sd1;
      vy_launch = $signed(6'd0 - (6'(charge[4:2]) + 6'd4));
      vx_launch = 3'sd0;
      if (right_s && !left_s)      vx_launch = 3'sd2;
      else if (left_s && !right_s) vx_launch = -3'sd2;
      x_right = (pos_x > X_MAX - 10'(WALK_SPD)) ? X_MAX : pos_x + 10'(WALK_SPD);
      x_left  = (pos_x < 10'(WALK_SPD)) ? 10'd0 : pos_x - 10'(WALK_SPD);
   end

   // armed remembers any jump press seen on the ground, so a press that
   // starts and ends between two frame ticks still launches.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         mode   <= PM_GROUND;
         pos_x  <= X_RESET;
         pos_y  <= Y_GROUND;
         vel_y  <= '0;
         vel_x  <= '0;
         charge <= '0;
         armed  <= 1'b0;
      end else begin
         if (mode == PM_GROUND && jump_s) armed <= 1'b1;
         if (frame_tick) begin
            case (mode)
               PM_GROUND: begin
                  if (jump_s) begin
                     if (charge != CHARGE_MAX) charge <= charge + 5'd1;
                  end else if (armed) begin
                     vel_y  <= vy_launch;
                     vel_x  <= vx_launch;
                     charge <= '0;
                     armed  <= 1'b0;
                     mode   <= PM_AIR;
                  end else if (right_s && !left_s) begin
                     pos_x <= x_right;
                  end else if (left_s && !right_s) begin
                     pos_x <= x_left;
                  end
               end
               PM_AIR: begin
                  vel_y <= vy_inc;
                  if (x_air < 12'sd0) begin
                     pos_x <= '0;
                     vel_x <= -vel_x;
                  end else if (x_air > $signed({2'b00, X_MAX})) begin
                     pos_x <= X_MAX;
                     vel_x <= -vel_x;
                  end else begin
                     pos_x <= x_air[9:0];
                  end
                  if (y_air >= $signed({2'b00, Y_GROUND})) begin
                     pos_y <= Y_GROUND;
                     vel_y <= '0;
                     vel_x <= '0;
                     mode  <= PM_GROUND;
                  end else begin
                     pos_y <= y_air[9:0];
                  end
               end
               default: mode <= PM_GROUND;
            endcase
         end
      end
   end

   logic        in_player, in_floor;
   logic [11:0] pix_col;

   always_comb begin
      in_player = ({1'b0, h_cnt} >= {1'b0, pos_x}) &&
                  ({1'b0, h_cnt} <  {1'b0, pos_x} + {1'b0, PLAYER_SIZE}) &&
                  ({1'b0, v_cnt} >= {1'b0, pos_y}) &&
                  ({1'b0, v_cnt} <  {1'b0, pos_y} + {1'b0, PLAYER_SIZE});
      in_floor  = (v_cnt >= FLOOR_TOP) && (v_cnt <= FLOOR_BOT);
      if (in_player)     pix_col = COL_PLAYER;
      else if (in_floor) pix_col = COL_FLOOR;
      else               pix_col = COL_SKY;
   end

   // Syncs and colour share one register stage so they stay aligned.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
         rgb   <= '0;
      end else if (pix_tick) begin
         hsync <= hs_raw;
         vsync <= vs_raw;
         rgb   <= visible ? pix_col : 12'h000;
      end
   end

   localparam logic [SCAN_BIT-1:0] DWELL_LOAD = '1;

   logic [SCAN_BIT-1:0] dwell_cnt;
   logic [2:0]          digit;
   logic [3:0]          nib;
   logic                blank;

   always_comb begin
      nib   = 4'h0;
      blank = 1'b0;
      case (digit)
         3'd0: nib = pos_y[3:0];
         3'd1: nib = pos_y[7:4];
         3'd2: nib = {2'b00, pos_y[9:8]};
         3'd3: blank = 1'b1;
         3'd4: nib = pos_x[3:0];
         3'd5: nib = pos_x[7:4];
         3'd6: nib = {2'b00, pos_x[9:8]};
         default: nib = charge[4:1];
      endcase
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         dwell_cnt <= DWELL_LOAD;
         digit     <= '0;
         AN        <= 8'hFF;
         {CA, CB, CC, CD, CE, CF, CG} <= 7'h7F;
      end else begin
         if (dwell_cnt == '0) begin
            dwell_cnt <= DWELL_LOAD;
            digit     <= digit + 3'd1;
         end else begin
            dwell_cnt <= dwell_cnt - SCAN_BIT'(1);
         end
         AN <= ~(8'd1 << digit);
         {CA, CB, CC, CD, CE, CF, CG} <= blank ? 7'h7F : hex_to_seg(nib);
      end
   end

   assign DP = 1'b1;

endmodule

// File: tb/tb_top_debug_game.sv
// Directed bench for top_debug_game on a shrunken raster (16x8 pixels,
// 2 clocks per pixel) so whole jumps fit in a short run.
module tb_top_debug_game;

   localparam int CLK_DIV  = 2;
   localparam int WALK_SPD = 2;
   localparam int SCAN_BIT = 2;
   localparam int H_VIS = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
   localparam int V_VIS = 4, V_FP = 1, V_SYNC = 1, V_BP = 2;
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        left      = 1'b0;
   logic        right     = 1'b0;
   logic        jump      = 1'b0;
   logic        hsync, vsync, DP;
   logic [11:0] rgb;
   logic        CA, CB, CC, CD, CE, CF, CG;
   logic [7:0]  AN;

   int         checks = 0;
   int         errors = 0;
   logic [6:0] cap [8];
   logic [7:0] seen;

   always #5 sys_clk = ~sys_clk;

   top_debug_game #(
      .CLK_DIV (CLK_DIV), .WALK_SPD (WALK_SPD), .SCAN_BIT (SCAN_BIT),
      .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) dut (
      .sys_clk (sys_clk), .sys_rst_n (sys_rst_n),
      .left (left), .right (right), .jump (jump),
      .hsync (hsync), .vsync (vsync), .rgb (rgb),
      .CA (CA), .CB (CB), .CC (CC), .CD (CD), .CE (CE), .CF (CF), .CG (CG),
      .DP (DP), .AN (AN)
   );

   // Standard hex glyphs written active high {a..g}, driven active low.
   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] on;
      case (n)
         4'h0: on = 7'b1111110;  4'h1: on = 7'b0110000;
         4'h2: on = 7'b1101101;  4'h3: on = 7'b1111001;
         4'h4: on = 7'b0110011;  4'h5: on = 7'b1011011;
         4'h6: on = 7'b1011111;  4'h7: on = 7'b1110000;
         4'h8: on = 7'b1111111;  4'h9: on = 7'b1111011;
         4'hA: on = 7'b1110111;  4'hB: on = 7'b0011111;
         4'hC: on = 7'b1001110;  4'hD: on = 7'b0111101;
         4'hE: on = 7'b1001111;  default: on = 7'b1000111;
      endcase
      return ~on;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   // Each vsync fall follows exactly one frame tick.
   task automatic wait_frames(input int n);
      for (int i = 0; i < n; i++) begin
         int cyc;
         cyc = 0;
         while (vsync !== 1'b1 && cyc < 1000) begin tick(1); cyc++; end
         while (vsync !== 1'b0 && cyc < 1000) begin tick(1); cyc++; end
         if (cyc >= 1000) chk("vsync_timeout", 32'(cyc), 32'd0);
      end
   endtask

   task automatic measure(input bit use_v, output int low_c, output int per_c);
      int cyc;
      cyc = 0;
      while ((use_v ? vsync : hsync) !== 1'b1 && cyc < 2000) begin tick(1); cyc++; end
      while ((use_v ? vsync : hsync) !== 1'b0 && cyc < 2000) begin tick(1); cyc++; end
      low_c = 0;
      per_c = 0;
      while ((use_v ? vsync : hsync) === 1'b0 && cyc < 2000) begin
         tick(1); cyc++; low_c++; per_c++;
      end
      while ((use_v ? vsync : hsync) === 1'b1 && cyc < 2000) begin
         tick(1); cyc++; per_c++;
      end
      if (cyc >= 2000) chk("sync_timeout", 32'(cyc), 32'd0);
   endtask

   task automatic check_display(input string tag, input logic [9:0] ex_x,
                                input logic [9:0] ex_y, input logic [3:0] ex_c);
      seen = '0;
      for (int i = 0; i < 80; i++) begin
         tick(1);
         for (int d = 0; d < 8; d++)
            if (AN == ~(8'd1 << d)) begin
               cap[d]  = {CA, CB, CC, CD, CE, CF, CG};
               seen[d] = 1'b1;
            end
      end
      chk($sformatf("%s_scan", tag), seen, 8'hFF);
      chk($sformatf("%s_y0", tag), cap[0], glyph(ex_y[3:0]));
      chk($sformatf("%s_y1", tag), cap[1], glyph(ex_y[7:4]));
      chk($sformatf("%s_y2", tag), cap[2], glyph({2'b00, ex_y[9:8]}));
      chk($sformatf("%s_blank", tag), cap[3], 7'h7F);
      chk($sformatf("%s_x4", tag), cap[4], glyph(ex_x[3:0]));
      chk($sformatf("%s_x5", tag), cap[5], glyph(ex_x[7:4]));
      chk($sformatf("%s_x6", tag), cap[6], glyph({2'b00, ex_x[9:8]}));
      chk($sformatf("%s_chg", tag), cap[7], glyph(ex_c));
   endtask

   initial begin
      int low_c, per_c, e;

      // Async reset takes effect before any clock edge.
      #2 sys_rst_n = 1'b1;
      #1;
      chk("rst_rgb", rgb, 12'h000);
      chk("rst_hsync", hsync, 1'b1);
      chk("rst_vsync", vsync, 1'b1);
      chk("rst_an", AN, 8'hFF);
      chk("rst_seg", {CA, CB, CC, CD, CE, CF, CG}, 7'h7F);
      chk("rst_dp", DP, 1'b1);
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b0;

      // Pixel p (= v*16+h) is on the outputs after edge 2p+2 until 2p+4.
      tick(41);  chk("pix_1_3_rgb", rgb, 12'h0AF);
      chk("pix_1_3_hs", hsync, 1'b1);
      tick(10);  chk("pix_1_8_rgb", rgb, 12'h000);
      chk("pix_1_8_hs", hsync, 1'b1);
      tick(4);   chk("pix_1_10_hs", hsync, 1'b0);
      chk("pix_1_10_rgb", rgb, 12'h000);
      tick(6);   chk("pix_1_13_hs", hsync, 1'b1);
      tick(52);  chk("pix_3_7_rgb", rgb, 12'h0AF);
      tick(48);  chk("pix_4_15_vs", vsync, 1'b1);
      tick(8);   chk("pix_5_3_vs", vsync, 1'b0);
      chk("pix_5_3_rgb", rgb, 12'h000);

      measure(1'b0, low_c, per_c);
      chk("hsync_low", 32'(low_c), 32'(H_SYNC * CLK_DIV));
      chk("hsync_period", 32'(per_c), 32'(H_TOT * CLK_DIV));
      measure(1'b1, low_c, per_c);
      chk("vsync_low", 32'(low_c), 32'(V_SYNC * H_TOT * CLK_DIV));
      chk("vsync_period", 32'(per_c), 32'(V_TOT * H_TOT * CLK_DIV));

      check_display("reset_pos", 10'd312, 10'd448, 4'h0);

      wait_frames(1);
      right = 1'b1;
      wait_frames(10);  check_display("walk10", 10'd332, 10'd448, 4'h0);
      wait_frames(150); check_display("walk_sat", 10'd624, 10'd448, 4'h0);
      left = 1'b1;
      wait_frames(3);   check_display("both", 10'd624, 10'd448, 4'h0);
      right = 1'b0;
      wait_frames(2);   check_display("walk_left", 10'd620, 10'd448, 4'h0);

      // Short jump with right held: vy=-4, vx=+2, bounce off x=624.
      left  = 1'b0;
      right = 1'b1;
      jump  = 1'b1;
      tick(10);
      jump  = 1'b0;
      wait_frames(1); check_display("short_launch", 10'd620, 10'd448, 4'h0);
      wait_frames(3); check_display("bounce_clamp", 10'd624, 10'd439, 4'h0);
      wait_frames(1); check_display("bounce_back", 10'd622, 10'd438, 4'h0);
      right = 1'b0;
      wait_frames(5); check_display("bounce_land", 10'd612, 10'd448, 4'h0);

      // Charge 20 frames with left held (no walking), then release.
      left = 1'b1;
      jump = 1'b1;
      wait_frames(20); check_display("charge20", 10'd612, 10'd448, 4'hA);
      jump = 1'b0;
      left = 1'b0;
      wait_frames(1);  check_display("charge_launch", 10'd612, 10'd448, 4'h0);
      wait_frames(8);  check_display("rise8", 10'd612, 10'd404, 4'h0);
      wait_frames(1);  check_display("apex", 10'd612, 10'd403, 4'h0);
      wait_frames(9);
      wait_frames(1);  check_display("pre_land", 10'd612, 10'd447, 4'h0);
      wait_frames(1);  check_display("landed", 10'd612, 10'd448, 4'h0);

      jump = 1'b1;
      wait_frames(2);  check_display("regrounded", 10'd612, 10'd448, 4'h1);
      jump = 1'b0;
      wait_frames(1);
      wait_frames(4);  check_display("apex2", 10'd612, 10'd438, 4'h0);

      // Reset at the apex.
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      #1;
      chk("mid_rst_an", AN, 8'hFF);
      chk("mid_rst_seg", {CA, CB, CC, CD, CE, CF, CG}, 7'h7F);
      chk("mid_rst_rgb", rgb, 12'h000);
      chk("mid_rst_hsync", hsync, 1'b1);
      chk("mid_rst_vsync", vsync, 1'b1);
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      e = 0;
      while (vsync !== 1'b0 && e < 1000) begin tick(1); e++; end
      chk("first_vsync_edge", 32'(e), 32'd162);
      check_display("after_reset", 10'd312, 10'd448, 4'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/top_debug_game.md
# top_debug_game

Debug top level of the jump game. One 16×16 player square walks left/right on a floor and performs charged jumps. The scene is rendered to a 640×480@60 VGA output, and the player state is shown on the 8-digit seven-segment display. The block sits directly on the board pins; module name is `top_debug_game`.

## Interface
Parameters:
- `CLK_DIV`, default 4: sys_clk cycles per pixel (100 MHz → 25 MHz pixel tick).
- `WALK_SPD`, default 2: px/frame horizontal speed.
- `SCAN_BIT`, default 17: seven-segment digit dwell is 2^SCAN_BIT cycles.

Ports:
- `sys_clk`, in, 1: single system clock, 100 MHz.
- `sys_rst_n`, in, 1: asynchronous, active-high reset. The name is historical; a 1 resets.
- `left`, in, 1: walk left button, asynchronous.
- `right`, in, 1: walk right button, asynchronous.
- `jump`, in, 1: jump button, asynchronous. Hold to charge, release to launch.
- `hsync`, out, 1: VGA horizontal sync, active low.
- `vsync`, out, 1: VGA vertical sync, active low.
- `rgb`, out, 12: colour as {R[3:0],G[3:0],B[3:0]}.
- `CA`..`CG`, out, 1 each: segments a–g, active low.
- `DP`, out, 1: decimal point, active low, held 1.
- `AN`, out, 8: digit enables, active low.

## Operation
- **Input conditioning:** `left`, `right` and `jump` pass through 2-FF synchronizers.
- **VGA timing:**
  - Horizontal: 800 pixel ticks per line (640 visible, 16 front porch, 96 sync, 48 back porch).
  - Vertical: 525 lines (480 visible, 10 front porch, 2 sync, 33 back porch).
  - `rgb` = 0 outside the visible area.
- **Frame tick:** one-cycle pulse when the counters reach h=0, v=480. All game state updates only on this tick.
- **Player state:**
  - x: 10-bit, range 0..624.
  - y: 10-bit top edge, 448 = grounded.
  - vy: signed 6-bit.
  - vx: signed.
  - charge: 5-bit.
  - grounded flag.
- **Grounded, jump not held:**
  - right only: x += WALK_SPD.
  - left only: x −= WALK_SPD.
  - Both or neither: no motion.
  - x saturates to 0..624.
- **Grounded, jump held:** charge += 1 per frame, saturating at 31. No walking while charging.
- **Launch:** on the first frame tick with jump released and charge-in-progress:
  - vy = −(charge[4:2] + 4).
  - vx = +2 if right, −2 if left, 0 if both or neither.
  - charge = 0; grounded = 0.
  - A press shorter than one frame launches with charge 0 (vy = −4).
- **Airborne, each frame:**
  - y += vy, then vy = min(vy + 1, 8).
  - x += vx. If x would leave 0..624, clamp it and negate vx (wall bounce).
  - If the new y ≥ 448: y = 448, vy = 0, vx = 0, grounded = 1.
  - Buttons are ignored while airborne.
- **Rendering priority:**
  1. Player square: 12'hF00.
  2. Floor rows 464..479: 12'h840.
  3. Background: 12'h0AF.
- **Seven-segment display:**
  - Digits 6..4: x in hex.
  - Digits 2..0: y in hex.
  - Digit 7: charge[4:1] in hex.
  - Digit 3: blank.
  - Hex decoding uses standard 0–F glyphs.

## Timing
- **Reset values (async, immediate):**
  - hsync = 1, vsync = 1, rgb = 0.
  - AN = 8'hFF, CA..CG = 1, DP = 1.
  - x = 312, y = 448, vy = 0, vx = 0, charge = 0, grounded = 1.
  - All counters = 0.
- **Reset mid-jump:** returns to the reset position. The first frame tick comes 480×800 pixel ticks after release of reset.
- **Output registers:** `hsync`, `vsync` and `rgb` are registered with identical 1-pixel-tick latency, so they stay mutually aligned.
- **Sync pulses in sys_clk cycles:**
  - hsync period 3200, low 384.
  - vsync period 1,680,000, low 6400.
- **Input latency:** a button edge affects state at the first frame tick at least 2 cycles after the edge.
- **Digit scan:** one digit every 2^17 cycles, cycling 0→7 and wrapping.

## Structure
- **Shared package `game_pkg`:**
  - VGA timing constants.
  - Screen, floor and player dimensions.
  - Colour constants.
  - Physics limits: 448, 624, 8, 31.
- **Sub-module `vga_sync_gen`:** pixel tick, h/v counters, sync, visible flag, frame tick.
- **Inline in the top:** physics and the seven-segment scan.

## Test plan
- **Reset:** assert `sys_rst_n` = 1 → immediately rgb = 0, hsync = 1, vsync = 1, AN = FF. Release → display shows x = 138, y = 1C0.
- **Sync timing:** free run → hsync low 384 of 3200 cycles; vsync low 6400 of 1,680,000. rgb = 0 during blanking.
- **Walk right:** hold `right` for 10 frames → x 312→332. Hold for 200 frames → x saturates at 624. Hold `left` and `right` together → x unchanged.
- **Charged jump:** hold `jump` for 20 frames → charge = 20. Release → vy = −9. Apex y = 403 after 9 frames. Lands at y = 448 and grounded = 1 within 20 frames.
- **Wall bounce:** from x = 620, `right` + short jump (vx = +2) → x clamps at 624, then decreases while airborne.
- **Reset mid-air:** assert reset at apex → x = 312, y = 448, charge = 0 immediately.
